// File: rtl/demux_fifo.sv
// Two-lane demultiplexing FIFO: alternating valid words are steered into lane 0 / lane 1,
// each lane a show-ahead circular FIFO with a sticky overflow flag.

module demux_fifo_lane #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             full,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign valid_out = (count != '0);
    assign full      = (count == CNT_W'(DEPTH));

    // A pop on an empty lane is ignored; a push into a full lane only lands if a pop frees the slot.
    assign do_pop  = pop && valid_out;
    assign do_push = push && (!full || do_pop);

    assign data_out = valid_out ? mem[rd_ptr] : '0;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        // NOTE: default assignment first so every path drives count_next and no latch is inferred.
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + CNT_W'(1);
        else if (do_pop && !do_push)
            count_next = count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset_L) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)
                rd_ptr <= next_ptr(rd_ptr);
            count <= count_next;
            if (push && !do_push)
                overflow <= 1'b1;
        end
    end

    // NOTE: storage is not reset; stale entries stay unobservable because data_out is gated by count.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= data_in;
    end

endmodule

module demux_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             pop_0,
    input  logic             pop_1,
    output logic [WIDTH-1:0] data_out_0,
    output logic [WIDTH-1:0] data_out_1,
    output logic             valid_out_0,
    output logic             valid_out_1,
    output logic             full_0,
    output logic             full_1,
    output logic             overflow_0,
    output logic             overflow_1,
    output logic             lane_sel
);

    logic push_0;
    logic push_1;

    assign push_0 = valid_in && !lane_sel;
    assign push_1 = valid_in && lane_sel;

    // lane_sel follows upstream alternation, so it toggles even when the word is dropped.
    always_ff @(posedge clk) begin
        if (!reset_L)
            lane_sel <= 1'b0;
        else if (valid_in)
            lane_sel <= !lane_sel;
    end

    demux_fifo_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_0 (
        .clk       (clk),
        .reset_L   (reset_L),
        .push      (push_0),
        .pop       (pop_0),
        .data_in   (data_in),
        .data_out  (data_out_0),
        .valid_out (valid_out_0),
        .full      (full_0),
        .overflow  (overflow_0)
    );

    demux_fifo_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane_1 (
        .clk       (clk),
        .reset_L   (reset_L),
        .push      (push_1),
        .pop       (pop_1),
        .data_in   (data_in),
        .data_out  (data_out_1),
        .valid_out (valid_out_1),
        .full      (full_1),
        .overflow  (overflow_1)
    );

endmodule

// File: tb/tb_demux_fifo.sv
// Self-checking bench for demux_fifo: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_demux_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset_L;
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             pop_0;
    logic             pop_1;
    logic [WIDTH-1:0] data_out_0;
    logic [WIDTH-1:0] data_out_1;
    logic             valid_out_0;
    logic             valid_out_1;
    logic             full_0;
    logic             full_1;
    logic             overflow_0;
    logic             overflow_1;
    logic             lane_sel;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .pop_0       (pop_0),
        .pop_1       (pop_1),
        .data_out_0  (data_out_0),
        .data_out_1  (data_out_1),
        .valid_out_0 (valid_out_0),
        .valid_out_1 (valid_out_1),
        .full_0      (full_0),
        .full_1      (full_1),
        .overflow_0  (overflow_0),
        .overflow_1  (overflow_1),
        .lane_sel    (lane_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each lane is a bounded queue; words alternate between lanes.
    logic [WIDTH-1:0] m_q0 [$];
    logic [WIDTH-1:0] m_q1 [$];
    bit               m_ovf0;
    bit               m_ovf1;
    bit               m_sel;

    always @(posedge clk) begin
        bit p0;
        bit p1;
        if (!reset_L) begin
            m_q0.delete();
            m_q1.delete();
            m_ovf0 = 1'b0;
            m_ovf1 = 1'b0;
            m_sel  = 1'b0;
        end else begin
            p0 = pop_0 && (m_q0.size() != 0);
            p1 = pop_1 && (m_q1.size() != 0);
            if (p0) void'(m_q0.pop_front());
            if (p1) void'(m_q1.pop_front());
            if (valid_in) begin
                if (!m_sel) begin
                    if (m_q0.size() < DEPTH) m_q0.push_back(data_in);
                    else m_ovf0 = 1'b1;
                end else begin
                    if (m_q1.size() < DEPTH) m_q1.push_back(data_in);
                    else m_ovf1 = 1'b1;
                end
                m_sel = !m_sel;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp data_out_0",  32'(data_out_0),  (m_q0.size() != 0) ? 32'(m_q0[0]) : 32'h0);
            check("cmp data_out_1",  32'(data_out_1),  (m_q1.size() != 0) ? 32'(m_q1[0]) : 32'h0);
            check("cmp valid_out_0", 32'(valid_out_0), 32'(m_q0.size() != 0));
            check("cmp valid_out_1", 32'(valid_out_1), 32'(m_q1.size() != 0));
            check("cmp full_0",      32'(full_0),      32'(m_q0.size() == DEPTH));
            check("cmp full_1",      32'(full_1),      32'(m_q1.size() == DEPTH));
            check("cmp overflow_0",  32'(overflow_0),  32'(m_ovf0));
            check("cmp overflow_1",  32'(overflow_1),  32'(m_ovf1));
            check("cmp lane_sel",    32'(lane_sel),    32'(m_sel));
        end
    end

    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic p0, input logic p1);
        valid_in = v;
        data_in  = d;
        pop_0    = p0;
        pop_1    = p1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " data_out_0"},  32'(data_out_0),  32'h0);
        check({tag, " data_out_1"},  32'(data_out_1),  32'h0);
        check({tag, " valid_out_0"}, 32'(valid_out_0), 32'h0);
        check({tag, " valid_out_1"}, 32'(valid_out_1), 32'h0);
        check({tag, " full_0"},      32'(full_0),      32'h0);
        check({tag, " full_1"},      32'(full_1),      32'h0);
        check({tag, " overflow_0"},  32'(overflow_0),  32'h0);
        check({tag, " overflow_1"},  32'(overflow_1),  32'h0);
        check({tag, " lane_sel"},    32'(lane_sel),    32'h0);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        cycle(1'b0, '0, 1'b0, 1'b0);
        reset_L = 1'b1;
    endtask

    initial begin
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        pop_0    = 1'b0;
        pop_1    = 1'b0;

        cycle(1'b0, '0, 1'b0, 1'b0);
        chk_en = 1'b1;
        cycle(1'b0, '0, 1'b0, 1'b0);
        check_reset_outputs("reset");
        reset_L = 1'b1;

        // Alternating steering and 1-cycle show-ahead latency
        cycle(1'b1, 4'h3, 1'b0, 1'b0);
        check("first head lane0", 32'(data_out_0), 32'h3);
        check("first valid lane0", 32'(valid_out_0), 32'h1);
        check("lane1 still empty", 32'(valid_out_1), 32'h0);
        cycle(1'b1, 4'hA, 1'b0, 1'b0);
        check("first head lane1", 32'(data_out_1), 32'hA);
        cycle(1'b1, 4'h5, 1'b0, 1'b0);
        cycle(1'b1, 4'hC, 1'b0, 1'b0);
        check("head0 after 4", 32'(data_out_0), 32'h3);
        check("head1 after 4", 32'(data_out_1), 32'hA);
        check("lane_sel after 4", 32'(lane_sel), 32'h0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("second word lane0", 32'(data_out_0), 32'h5);
        check("second word lane1", 32'(data_out_1), 32'hC);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("drained valid0", 32'(valid_out_0), 32'h0);
        check("drained data0", 32'(data_out_0), 32'h0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("pop on empty no flag", 32'(overflow_0), 32'h0);
        check("pop on empty valid1", 32'(valid_out_1), 32'h0);

        // Fill both lanes, then overflow each with one word
        for (int i = 1; i <= 2 * DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
        check("full_0 after 8", 32'(full_0), 32'h1);
        check("full_1 after 8", 32'(full_1), 32'h1);
        check("no overflow yet", 32'(overflow_0), 32'h0);
        cycle(1'b1, 4'h9, 1'b0, 1'b0);
        cycle(1'b1, 4'hA, 1'b0, 1'b0);
        check("overflow_0 set", 32'(overflow_0), 32'h1);
        check("overflow_1 set", 32'(overflow_1), 32'h1);
        check("head0 unchanged", 32'(data_out_0), 32'h1);
        check("head1 unchanged", 32'(data_out_1), 32'h2);

        // Push and pop together on a full lane
        do_reset();
        for (int i = 1; i <= 2 * DEPTH; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
        cycle(1'b1, 4'hE, 1'b1, 1'b0);
        check("full push+pop full_0", 32'(full_0), 32'h1);
        check("full push+pop ovf_0", 32'(overflow_0), 32'h0);
        check("full push+pop head", 32'(data_out_0), 32'h3);
        for (int k = 0; k < 4; k++) cycle(1'b0, '0, (k < 3), 1'b1);
        check("new word at tail", 32'(data_out_0), 32'hE);
        check("lane1 drained", 32'(valid_out_1), 32'h0);

        // Push and pop together on an empty lane
        cycle(1'b1, 4'h7, 1'b0, 1'b1);
        check("empty push+pop valid1", 32'(valid_out_1), 32'h1);
        check("empty push+pop data1", 32'(data_out_1), 32'h7);

        // lane_sel holds across valid_in gaps
        cycle(1'b1, 4'h9, 1'b0, 1'b0);
        check("gap sel after word", 32'(lane_sel), 32'h1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("gap sel hold 1", 32'(lane_sel), 32'h1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("gap sel hold 2", 32'(lane_sel), 32'h1);
        cycle(1'b1, 4'hB, 1'b0, 1'b0);
        check("gap sel toggled", 32'(lane_sel), 32'h0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("gap word lane0", 32'(data_out_0), 32'h9);
        check("gap word lane1", 32'(data_out_1), 32'hB);

        // Mid-operation reset with buffered words and overflow set
        do_reset();
        for (int i = 1; i <= 2 * DEPTH + 2; i++) cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        check("pre-reset head0", 32'(data_out_0), 32'h3);
        check("pre-reset head1", 32'(data_out_1), 32'h4);
        check("pre-reset ovf0", 32'(overflow_0), 32'h1);
        reset_L = 1'b0;
        cycle(1'b1, 4'hF, 1'b1, 1'b1);
        reset_L = 1'b1;
        check_reset_outputs("mid reset");
        cycle(1'b1, 4'h6, 1'b0, 1'b0);
        check("post-reset lane0", 32'(data_out_0), 32'h6);
        check("post-reset lane1 empty", 32'(valid_out_1), 32'h0);
        check("post-reset sel", 32'(lane_sel), 32'h1);

        cycle(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_fifo.md
DEMUX_FIFO -- requirements
Module: demux_fifo

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the entries per lane FIFO (power of two, >=2).

Interface
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset_L  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port data_in  input  WIDTH  serialized word from the upstream 2:1 mux data_out.
REQ-006 The block SHALL have port valid_in  input  1  data_in carries a word this cycle.
REQ-007 The block SHALL have ports pop_0 and pop_1  input  1 each  consumer takes the head word of lane 0 / lane 1.
REQ-008 The block SHALL have ports data_out_0 and data_out_1  output  WIDTH each  head word of lane 0 / lane 1.
REQ-009 The block SHALL have ports valid_out_0 and valid_out_1  output  1 each  lane non-empty.
REQ-010 The block SHALL have ports full_0 and full_1  output  1 each  lane holds DEPTH words.
REQ-011 The block SHALL have ports overflow_0 and overflow_1  output  1 each  sticky: a word for that lane was dropped.
REQ-012 The block SHALL have port lane_sel  output  1  lane that receives the next valid_in word.

Function
REQ-013 On each cycle with valid_in=1, the block SHALL steer data_in to lane lane_sel, then toggle lane_sel (0->1->0...).
REQ-014 lane_sel SHALL toggle on every valid_in=1 cycle, including dropped words, so lane order matches upstream data_0/data_1 alternation.
REQ-015 lane_sel SHALL hold when valid_in=0.
REQ-016 Each lane SHALL be a circular FIFO with WIDTH x DEPTH storage, rd/wr pointers wrapping DEPTH-1 -> 0, and a count 0..DEPTH.
REQ-017 A word written at edge N SHALL be visible on data_out_x with valid_out_x=1 from that edge onward (1-cycle latency, show-ahead head).
REQ-018 data_out_x SHALL equal the entry at rd pointer when count>0 and WIDTH'b0 when count=0.
REQ-019 A pop SHALL occur only when pop_x=1 and valid_out_x=1; it advances rd pointer and decrements count at the edge.
REQ-020 A pop_x with valid_out_x=0 SHALL be ignored, with no state change and no flag.
REQ-021 A push to a lane with count=DEPTH and no simultaneous pop SHALL be dropped, leave storage unchanged, and set overflow_x=1.
REQ-022 A simultaneous push and pop on a full lane SHALL perform both; count stays DEPTH, and overflow_x is unchanged.
REQ-023 A simultaneous push and pop on an empty lane SHALL accept the push, ignore the pop, and leave count=1.
REQ-024 Push and pop on a lane with 0<count<DEPTH in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-025 full_x SHALL equal (count_x==DEPTH) and valid_out_x SHALL equal (count_x!=0); both SHALL be derived from registered count only.
REQ-026 overflow_x SHALL remain 1 until reset.
REQ-027 Operations on lane 0 SHALL NOT affect lane 1, and vice versa.

Reset
REQ-028 At a rising edge with reset_L=0, the block SHALL clear counts, pointers, lane_sel and overflow_0/1, regardless of valid_in/pop.
REQ-029 After reset, outputs SHALL be: data_out_0/1=0, valid_out_0/1=0, full_0/1=0, overflow_0/1=0, lane_sel=0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered words; storage contents need not be cleared but SHALL be unobservable.
REQ-031 The first valid_in word after reset_L returns high SHALL go to lane 0.

Verification
REQ-032 Bench SHALL cover: reset, then valid_in=1 with data_in 4'h3, 4'hA, 4'h5, 4'hC on consecutive cycles -> lane 0 holds 3,5 and lane 1 holds A,C; data_out_0=3 and data_out_1=A one cycle after first writes.
REQ-033 Bench SHALL cover: 2*DEPTH+2 words with no pops -> full_0=full_1=1 after 8 words; words 9 and 10 dropped; overflow_0=overflow_1=1; heads unchanged.
REQ-034 Bench SHALL cover: lane 0 full, with push and pop_0=1 in the same cycle -> count stays 4, new word is at the tail, overflow_0 stays 0, and head advances to the second word.
REQ-035 Bench SHALL cover: empty lane 1, push 4'h7 with pop_1=1 in the same cycle -> next cycle valid_out_1=1, data_out_1=7.
REQ-036 Bench SHALL cover: valid_in gaps (1,0,0,1) -> lane_sel holds during gaps, and the second word goes to lane 1.
REQ-037 Bench SHALL cover: reset_L=0 for one cycle with both lanes holding 3 words and overflow set -> next cycle all outputs at reset values, and the following word lands in lane 0.
